// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the MIPS data-memory controller.
package dm_pkg;

    // Access size encodings as carried on req_size.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // Controller FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EXEC = 2'd2,
        RESP = 2'd3
    } state_e;

    // True when the size is illegal or the low address bits break natural alignment.
    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lo[0];
            SZ_WORD: bad = (lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_ctrl_if.sv
// Request/response bundle between MEM-stage control and the data memory.
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// a response transfers on a rising edge where rsp_valid && rsp_ready. The
// requester holds req_valid and its fields until accepted; the responder holds
// rsp_rdata/rsp_err stable while rsp_valid is high and not yet accepted.
interface dm_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_lane_align.sv
// Big-endian lane steering: load extract/extend from a 4-byte window and
// store lane enables/data. Lane i is byte (base+i), held in bits [31-8i -: 8].
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_signed,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_win,
    output logic [31:0] ld_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half out of the window and extend it.
    always_comb begin
        byte_sel = 8'h00;
        case (off)
            2'd0: byte_sel = rd_win[31:24];
            2'd1: byte_sel = rd_win[23:16];
            2'd2: byte_sel = rd_win[15:8];
            default: byte_sel = rd_win[7:0];
        endcase
        half_sel = off[1] ? rd_win[15:0] : rd_win[31:16];
        case (size)
            SZ_BYTE: ld_data = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
            SZ_HALF: ld_data = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
            default: ld_data = rd_win;
        endcase
    end

    // Replicate store data across lanes; the enables pick which lanes commit.
    always_comb begin
        st_be    = 4'b0000;
        st_lanes = wdata;
        case (size)
            SZ_BYTE: begin
                st_lanes = {4{wdata[7:0]}};
                st_be    = 4'b0001 << off;
            end
            SZ_HALF: begin
                st_lanes = {2{wdata[15:0]}};
                st_be    = off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_lanes = wdata;
                st_be    = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/dm_ctrl.sv
// Byte-addressed data memory with a single-outstanding request/response FSM.
module dm_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int WAIT_CYCLES  = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic   clk,
    input  logic   rst,
    dm_ctrl_if.slave bus,
    output state_e dbg_state
);

    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [7:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [ADDR_W-1:0] base;
    logic [31:0]       rd_win;
    logic [31:0]       ld_data;
    logic [3:0]        st_be;
    logic [31:0]       st_lanes;
    logic              err;
    logic              commit;

    assign base   = {addr_q[ADDR_W-1:2], 2'b00};
    assign rd_win = {mem[base], mem[base + ADDR_W'(1)], mem[base + ADDR_W'(2)], mem[base + ADDR_W'(3)]};
    assign err    = size_misaligned(size_q, addr_q[1:0]) | ((addr_q >> ADDR_W) != 32'd0);
    assign commit = (state_q == EXEC) && we_q && !err;

    dm_lane_align u_align (
        .size      (size_q),
        .is_signed (signed_q),
        .off       (addr_q[1:0]),
        .wdata     (wdata_q),
        .rd_win    (rd_win),
        .ld_data   (ld_data),
        .st_be     (st_be),
        .st_lanes  (st_lanes)
    );

    // Next-state and next-output computation for the request FSM.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        we_d        = we_q;
        size_d      = size_q;
        signed_d    = signed_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d        = bus.req_we;
                    size_d      = bus.req_size;
                    signed_d    = bus.req_signed;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = EXEC;
                else               cnt_d   = cnt_q - 4'd1;
            end
            EXEC: begin
                rsp_err_d   = err;
                rsp_rdata_d = (err || we_q) ? 32'h0 : ld_data;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            default: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    // FSM and registered handshake outputs; reset abandons any request in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            size_q      <= SZ_BYTE;
            signed_q    <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            size_q      <= size_d;
            signed_q    <= signed_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

    generate
        if (CLEAR_ON_RST != 0) begin : g_mem_clr
            // Storage with reset clear; store lanes commit on the EXEC edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int j = 0; j < DEPTH; j++) mem[j] <= 8'h00;
                end else if (commit) begin
                    for (int i = 0; i < 4; i++)
                        if (st_be[i]) mem[base + ADDR_W'(i)] <= st_lanes[31-8*i -: 8];
                end
            end
        end else begin : g_mem_keep
            // Storage untouched by reset; store lanes commit on the EXEC edge.
            always_ff @(posedge clk) begin
                if (commit) begin
                    for (int i = 0; i < 4; i++)
                        if (st_be[i]) mem[base + ADDR_W'(i)] <= st_lanes[31-8*i -: 8];
                end
            end
        end
    endgenerate

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl: loads/stores, extension, errors, backpressure, reset abandon.
module tb_dm_ctrl;
    import dm_pkg::*;

    logic   clk;
    logic   rst;
    state_e dbg_state;
    int     n_checks = 0;
    int     n_errors = 0;
    logic [31:0] exp_q[$];

    dm_ctrl_if bus();

    dm_ctrl #(.ADDR_W(10), .WAIT_CYCLES(1), .CLEAR_ON_RST(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus();
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.rsp_ready  = 1'b0;
    endtask

    // One full transaction; hold > 0 keeps rsp_ready low that many cycles
    // and offers a stray store to 0x010 meanwhile, which must be ignored.
    task automatic txn(input string tag, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int hold);
        int edges;
        int guard;
        logic [31:0] exp_d;
        exp_q.push_back(exp_rdata);
        @(negedge clk);
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid = 1'b0;
        edges = 1;
        while (!bus.rsp_valid && edges < 30) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, "_latency"}, 32'(edges), 32'd3);
        exp_d = exp_q.pop_front();
        check({tag, "_rdata"}, bus.rsp_rdata, exp_d);
        check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        for (int c = 0; c < hold; c++) begin
            if (c == 1) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_size  = SZ_WORD;
                bus.req_addr  = 32'h010;
                bus.req_wdata = 32'h0;
            end
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
            check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_d);
            check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
            check({tag, "_hold_state"}, 32'(dbg_state), 32'(RESP));
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({tag, "_done_valid"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, "_done_state"}, 32'(dbg_state), 32'(IDLE));
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst = 1'b0;

        txn("sw_010",   1'b1, SZ_WORD, 1'b0, 32'h010, 32'h12345678, 32'h0,        1'b0, 0);
        txn("lw_010",   1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0,        32'h12345678, 1'b0, 0);
        txn("lb_011",   1'b0, SZ_BYTE, 1'b1, 32'h011, 32'h0,        32'h00000034, 1'b0, 0);
        txn("lhu_012",  1'b0, SZ_HALF, 1'b0, 32'h012, 32'h0,        32'h00005678, 1'b0, 0);
        txn("lh_010",   1'b0, SZ_HALF, 1'b1, 32'h010, 32'h0,        32'h00001234, 1'b0, 0);
        txn("sb_013",   1'b1, SZ_BYTE, 1'b0, 32'h013, 32'hFFFFFFF0, 32'h0,        1'b0, 0);
        txn("lb_013",   1'b0, SZ_BYTE, 1'b1, 32'h013, 32'h0,        32'hFFFFFFF0, 1'b0, 0);
        txn("lbu_013",  1'b0, SZ_BYTE, 1'b0, 32'h013, 32'h0,        32'h000000F0, 1'b0, 0);
        txn("lw_010b",  1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0,        32'h123456F0, 1'b0, 0);
        txn("sh_016",   1'b1, SZ_HALF, 1'b0, 32'h016, 32'h00008001, 32'h0,        1'b0, 0);
        txn("lh_016",   1'b0, SZ_HALF, 1'b1, 32'h016, 32'h0,        32'hFFFF8001, 1'b0, 0);
        txn("lh_011",   1'b0, SZ_HALF, 1'b1, 32'h011, 32'h0,        32'h0,        1'b1, 0);
        txn("sw_012",   1'b1, SZ_WORD, 1'b0, 32'h012, 32'hDEADBEEF, 32'h0,        1'b1, 0);
        txn("lw_010c",  1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0,        32'h123456F0, 1'b0, 0);
        txn("lw_400",   1'b0, SZ_WORD, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1, 0);
        txn("ill_size", 1'b0, SZ_ILL,  1'b0, 32'h010, 32'h0,        32'h0,        1'b1, 0);
        txn("lw_hold",  1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0,        32'h123456F0, 1'b0, 5);
        txn("lw_after", 1'b0, SZ_WORD, 1'b0, 32'h010, 32'h0,        32'h123456F0, 1'b0, 0);

        // Known contents at 0x020, then a store abandoned by reset during WAIT.
        txn("sw_020z",  1'b1, SZ_WORD, 1'b0, 32'h020, 32'h0,        32'h0,        1'b0, 0);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = SZ_WORD;
        bus.req_addr  = 32'h020;
        bus.req_wdata = 32'hAAAAAAAA;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("abort_in_wait", 32'(dbg_state), 32'(WAIT));
        rst = 1'b1;
        #1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rsp_rdata", bus.rsp_rdata, 32'h0);
        check("abort_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("abort_state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        txn("lw_020",   1'b0, SZ_WORD, 1'b0, 32'h020, 32'h0,        32'h0,        1'b0, 0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
Parametrised byte-addressed data memory for the MIPS datapath, with a request/response handshake.
- Supports byte, halfword and word accesses, big-endian lane order.
- Sign/zero extension on loads (LB/LBU/LH/LHU/LW, SB/SH/SW).
- Configurable access latency, misalignment and range error reporting.
- Sits between the MEM-stage control and the storage array; the pipeline stalls on req_ready/rsp_valid.

Parameters:
ADDR_W, 10, byte-address bits actually decoded; depth = 2**ADDR_W bytes
WAIT_CYCLES, 1, extra cycles between request accept and response (0..15)
CLEAR_ON_RST, 1, 1 = rst zeroes every storage byte; 0 = contents untouched by rst

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts response
rsp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
rsp_err  out  1  request misaligned, out of range, or illegal size

Behaviour:
- Reset (async): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0.
  - CLEAR_ON_RST=1: all bytes zeroed.
  - Reset mid-operation abandons the request; a pending store is not committed.
- FSM IDLE:
  - req_ready=1.
  - req_valid=1 latches we/size/signed/addr/wdata.
  - Next state: WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else EXEC.
- FSM WAIT:
  - req_ready=0.
  - Counter decrements each cycle; at 0 go to EXEC.
- FSM EXEC (one cycle):
  - Error check: err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0) | (addr[31:ADDR_W]!=0).
  - No error, store: commit the addressed lanes on this edge.
    - Byte: mem[a]=wdata[7:0].
    - Half: mem[a]=wdata[15:8], mem[a+1]=wdata[7:0].
    - Word: mem[a..a+3]=wdata[31:24..7:0].
  - No error, load: big-endian assemble, then extend per size/signed; register into rsp_rdata.
  - Error: no storage change, rsp_rdata=0, rsp_err=1.
  - Next state: RESP.
- FSM RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready=1.
  - On that edge: rsp_valid=0, go to IDLE.
  - req_ready stays 0 until IDLE (single outstanding request).
- Total latency, accept edge to first rsp_valid cycle: WAIT_CYCLES+2 edges.
  - Accept edge → (WAIT_CYCLES cycles) → EXEC → RESP.
- Addresses never wrap: misalignment rules guarantee a+3 ≤ depth-1 for legal accesses.
- Load of a location returns the most recent committed store (no bypass needed; single outstanding).
- req_valid while req_ready=0 is ignored; the requester must hold it.

Decomposition:
- Package dm_pkg:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - state enum IDLE/WAIT/EXEC/RESP.
  - function size_misaligned(size, addr[1:0]).
- Sub-module dm_lane_align (combinational):
  - Load extract + sign/zero extend from a 4-byte fetched window.
  - Store lane-enable/data steering.
- Storage array and FSM stay in dm_ctrl.

Test Plan:
- SW 0x12345678 @0x010, then LW @0x010 → rsp_rdata=0x12345678, rsp_err=0; with WAIT_CYCLES=1, rsp_valid 3 edges after accept.
- After the above: LB signed @0x011 → 0x00000034; LH unsigned @0x012 → 0x00005678.
- SB 0xF0 @0x013, then LB signed @0x013 → 0xFFFFFFF0; LBU @0x013 → 0x000000F0; LW @0x010 → 0x123456F0.
- LH @0x011 → rsp_err=1, rsp_rdata=0. SW 0xDEADBEEF @0x012 → rsp_err=1, and a following LW @0x010 is still 0x123456F0. LW @0x400 (ADDR_W=10) → rsp_err=1.
- Hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_rdata stable, req_ready=0, a new req_valid is ignored; rsp_ready=1 → IDLE next cycle.
- Issue SW 0xAAAAAAAA @0x020 and assert rst during WAIT → outputs at reset values immediately. With CLEAR_ON_RST=0, LW @0x020 after reset → 0x00000000 (store never committed).
